// File: rtl/vpu_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package vpu_pkg;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CSUM} loader_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   localparam logic [7:0] FRAME_HEADER    = 8'hA5;
   localparam int         INSTR_WIDTH_DEF = 32;
   localparam int         BYTES_PER_INSTR = INSTR_WIDTH_DEF / 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx_byte
   import vpu_pkg::*;
#(
   parameter int CLK_PER_BIT = 54
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int            CW       = $clog2(CLK_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_END = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_meta, rx_sync, rx_prev;
   logic          valid_d, ferr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: synchroniser resets to the idle-high level so reset release never looks like a start edge.
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         state_q    <= R_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= uart_rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_valid <= valid_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (rx_prev && !rx_sync) state_d = R_START;
         end
         R_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (cnt_q == HALF_END) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_q == FULL_END) begin
               cnt_d   = '0;
               shift_d = {rx_sync, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = R_STOP;
            end
         end
         R_STOP: begin
            if (cnt_q == FULL_END) begin
               state_d = R_IDLE;
               valid_d = rx_sync;
               ferr_d  = !rx_sync;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign byte_data = shift_q;

endmodule

// File: rtl/uart_instr_loader.sv
// Frame decoder that writes a UART-delivered program image into instruction memory
// and holds the control FSM in reset until a good image has been loaded.
module uart_instr_loader
   import vpu_pkg::*;
#(
   parameter int F_CLK          = 50_000_000,
   parameter int BAUD           = 921_600,
   parameter int CLK_PER_BIT    = F_CLK / BAUD,
   parameter int INSTR_WIDTH    = 8 * BYTES_PER_INSTR,
   parameter int INSTR_DEPTH    = 256,
   parameter int PC_WIDTH       = $clog2(INSTR_DEPTH),
   parameter int TIMEOUT_CYCLES = CLK_PER_BIT * 160
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx,
   output logic                   wr_en,
   output logic [PC_WIDTH-1:0]    wr_addr,
   output logic [INSTR_WIDTH-1:0] wr_data,
   output logic                   busy,
   output logic                   load_done,
   output logic                   load_err,
   output logic [PC_WIDTH:0]      instr_count,
   output logic                   fsm_hold
);

   localparam int NBYTES = INSTR_WIDTH / 8;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int NW     = PC_WIDTH + 1;
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

   logic                   byte_valid, frame_err;
   logic [7:0]             byte_data;
   loader_state_t          state_q, state_d;
   logic [NW-1:0]          n_words_q, word_idx_q;
   logic [BW-1:0]          byte_idx_q;
   logic [INSTR_WIDTH-1:0] word_q, next_word;
   logic [7:0]             csum_q;
   logic [TW-1:0]          timer_q;
   logic                   err_q, no_program_q;
   logic                   timeout, abort, word_done, last_word, csum_ok;

   uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   assign busy      = (state_q != S_IDLE);
   assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES));
   // An arriving byte always beats a same-cycle timeout.
   assign abort     = busy && !byte_valid && (frame_err || timeout);
   assign word_done = (state_q == S_DATA) && byte_valid && (byte_idx_q == BW'(NBYTES - 1));
   assign last_word = (word_idx_q == n_words_q - 1'b1);
   assign csum_ok   = (byte_data == csum_q);
   assign next_word = (word_q << 8) | INSTR_WIDTH'(byte_data);
   // Held through the load_done cycle so release is always one cycle later.
   assign fsm_hold  = busy | err_q | no_program_q | load_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (byte_valid && byte_data == FRAME_HEADER) state_d = S_COUNT;
         S_COUNT: if (byte_valid) state_d = S_DATA;
         S_DATA:  if (word_done && last_word) state_d = S_CSUM;
         S_CSUM:  if (byte_valid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         instr_count  <= '0;
         n_words_q    <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         timer_q      <= '0;
         err_q        <= 1'b0;
         no_program_q <= 1'b1;
      end else begin
         wr_en     <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;

         if (!busy || byte_valid) timer_q <= '0;
         else if (!timeout)       timer_q <= timer_q + 1'b1;

         case (state_q)
            S_COUNT: if (byte_valid) begin
               n_words_q  <= (byte_data == 8'd0) ? NW'(INSTR_DEPTH) : NW'(byte_data);
               csum_q     <= byte_data;
               word_idx_q <= '0;
               byte_idx_q <= '0;
            end
            S_DATA: if (byte_valid) begin
               word_q <= next_word;
               csum_q <= csum_q ^ byte_data;
               if (word_done) begin
                  byte_idx_q <= '0;
                  wr_en      <= 1'b1;
                  wr_addr    <= word_idx_q[PC_WIDTH-1:0];
                  wr_data    <= next_word;
                  word_idx_q <= word_idx_q + 1'b1;
               end else begin
                  byte_idx_q <= byte_idx_q + 1'b1;
               end
            end
            S_CSUM: if (byte_valid) begin
               if (csum_ok) begin
                  load_done    <= 1'b1;
                  instr_count  <= n_words_q;
                  err_q        <= 1'b0;
                  no_program_q <= 1'b0;
               end else begin
                  load_err <= 1'b1;
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase

         if (abort) begin
            load_err <= 1'b1;
            err_q    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed-vector bench for uart_instr_loader, run at 4 clocks per UART bit.
module tb_uart_instr_loader;

   localparam int F_CLK = 4_000_000;
   localparam int BAUD  = 1_000_000;
   localparam int CPB   = F_CLK / BAUD;
   localparam int W     = 32;
   localparam int DEPTH = 256;
   localparam int PCW   = 8;

   logic           clk     = 1'b0;
   logic           rst     = 1'b1;
   logic           uart_rx = 1'b1;
   logic           wr_en, busy, load_done, load_err, fsm_hold;
   logic [PCW-1:0] wr_addr;
   logic [W-1:0]   wr_data;
   logic [PCW:0]   instr_count;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int hold_bad = 0;
   logic done_prev = 1'b0;
   logic [PCW-1:0] wa_q[$];
   logic [W-1:0]   wd_q[$];
   logic [7:0]     tx_q[$];

   uart_instr_loader #(
      .F_CLK(F_CLK), .BAUD(BAUD), .INSTR_WIDTH(W), .INSTR_DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx     (uart_rx),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .load_done   (load_done),
      .load_err    (load_err),
      .instr_count (instr_count),
      .fsm_hold    (fsm_hold)
   );

   always #5 clk = ~clk;

   // Event log sampled on the falling edge, half a cycle clear of DUT updates.
   always @(negedge clk) begin
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
         end
         if (load_done) done_cnt++;
         if (load_err) err_cnt++;
         if (load_done && fsm_hold !== 1'b1) hold_bad++;
         if (done_prev && fsm_hold !== 1'b0) hold_bad++;
         done_prev = load_done;
      end
   end

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      hold_bad = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rx = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_cycles(CPB);
      end
      uart_rx = stop_bit;
      wait_cycles(CPB);
      uart_rx = 1'b1;
   endtask

   task automatic send_tx();
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
      tx_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cycles(3);
      n_cmp++;
      if ({wr_en, busy, load_done, load_err, fsm_hold} !== 5'b00001) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00001", {wr_en, busy, load_done, load_err, fsm_hold});
      end
      n_cmp++;
      if ({instr_count, wr_addr, wr_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: count=%0d addr=%0d data=%h want all 0", instr_count, wr_addr, wr_data);
      end
      rst = 1'b0;
      wait_cycles(20);
      n_cmp++;
      if ({busy, fsm_hold} !== 2'b01) begin
         n_bad++;
         $display("FAIL idle_after_reset busy/hold: got %b want 01", {busy, fsm_hold});
      end
   endtask

   task automatic test_good_frame();
      logic [PCW-1:0] a;
      logic [W-1:0]   d;
      logic [W-1:0]   exp_d[2];
      exp_d = '{32'h11223344, 32'h55667788};
      clear_log();
      // 02^11^22^33^44^55^66^77^88 = 8A
      tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
      send_tx();
      wait_cycles(20);
      n_cmp++;
      if (wa_q.size() !== 2) begin
         n_bad++;
         $display("FAIL good_write_count: got %0d want 2", wa_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         a = (i < wa_q.size()) ? wa_q[i] : 'x;
         d = (i < wd_q.size()) ? wd_q[i] : 'x;
         n_cmp++;
         if ({a, d} !== {PCW'(i), exp_d[i]}) begin
            n_bad++;
            $display("FAIL good_write%0d: got addr %0d data %h want addr %0d data %h", i, a, d, i, exp_d[i]);
         end
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
         n_bad++;
         $display("FAIL good_pulses: done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
      n_cmp++;
      if (instr_count !== 9'd2) begin
         n_bad++;
         $display("FAIL good_instr_count: got %0d want 2", instr_count);
      end
      n_cmp++;
      if ({fsm_hold, busy, hold_bad} !== {1'b0, 1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL good_hold_release: hold=%b busy=%b hold_timing_errs=%0d want 0/0/0", fsm_hold, busy, hold_bad);
      end
   endtask

   task automatic test_bad_csum();
      clear_log();
      tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h0B};
      send_tx();
      wait_cycles(20);
      n_cmp++;
      if (wa_q.size() !== 2) begin
         n_bad++;
         $display("FAIL badcsum_write_count: got %0d want 2", wa_q.size());
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd0, 32'd1}) begin
         n_bad++;
         $display("FAIL badcsum_pulses: done=%0d err=%0d want 0/1", done_cnt, err_cnt);
      end
      n_cmp++;
      if ({instr_count, fsm_hold} !== {9'd2, 1'b1}) begin
         n_bad++;
         $display("FAIL badcsum_state: count=%0d hold=%b want 2/1", instr_count, fsm_hold);
      end
   endtask

   task automatic test_leading_noise();
      logic [PCW-1:0] a;
      logic [W-1:0]   d;
      clear_log();
      tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
      send_tx();
      wait_cycles(20);
      a = (wa_q.size() > 0) ? wa_q[0] : 'x;
      d = (wd_q.size() > 0) ? wd_q[0] : 'x;
      n_cmp++;
      if ({32'(wa_q.size()), a, d} !== {32'd1, 8'd0, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL noise_write: n=%0d addr=%0d data=%h want 1 write addr 0 data deadbeef", wa_q.size(), a, d);
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
         n_bad++;
         $display("FAIL noise_pulses: done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
      n_cmp++;
      if ({instr_count, fsm_hold, hold_bad} !== {9'd1, 1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL noise_state: count=%0d hold=%b hold_timing_errs=%0d want 1/0/0", instr_count, fsm_hold, hold_bad);
      end
   endtask

   task automatic test_frame_err();
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hDE, 1'b1);
      wait_cycles(2);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ferr_busy_in_frame: got %b want 1", busy);
      end
      send_byte(8'hAD, 1'b0);
      wait_cycles(20);
      n_cmp++;
      if ({32'(wa_q.size()), err_cnt, done_cnt} !== {32'd0, 32'd1, 32'd0}) begin
         n_bad++;
         $display("FAIL ferr_abort: writes=%0d err=%0d done=%0d want 0/1/0", wa_q.size(), err_cnt, done_cnt);
      end
      n_cmp++;
      if ({busy, fsm_hold} !== 2'b01) begin
         n_bad++;
         $display("FAIL ferr_state: busy=%b hold=%b want 0/1", busy, fsm_hold);
      end
      clear_log();
      tx_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
      send_tx();
      wait_cycles(20);
      n_cmp++;
      if ({done_cnt, 32'(wd_q.size())} !== {32'd1, 32'd1} || wd_q[0] !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL ferr_recover: done=%0d writes=%0d want 1/1 with data deadbeef", done_cnt, wd_q.size());
      end
   endtask

   task automatic test_timeout();
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hDE, 1'b1);
      wait_cycles(300);
      n_cmp++;
      if ({err_cnt, busy} !== {32'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL timeout_early: err=%0d busy=%b want 0/1", err_cnt, busy);
      end
      wait_cycles(500);
      n_cmp++;
      if ({err_cnt, busy} !== {32'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL timeout_abort: err=%0d busy=%b want 1/0", err_cnt, busy);
      end
      wait_cycles(700);
      n_cmp++;
      if ({err_cnt, 32'(wa_q.size()), fsm_hold} !== {32'd1, 32'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL timeout_once: err=%0d writes=%0d hold=%b want 1/0/1", err_cnt, wa_q.size(), fsm_hold);
      end
   endtask

   task automatic test_full_depth();
      logic [PCW-1:0] a;
      logic [W-1:0]   d;
      logic [W-1:0]   exp;
      clear_log();
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'h00);
      for (int i = 0; i < 4 * DEPTH; i++) tx_q.push_back(8'(i));
      // Each value 0..FF appears four times, so the XOR of the data is 0.
      tx_q.push_back(8'h00);
      send_tx();
      wait_cycles(20);
      n_cmp++;
      if (wa_q.size() !== DEPTH) begin
         n_bad++;
         $display("FAIL depth_write_count: got %0d want %0d", wa_q.size(), DEPTH);
      end
      for (int k = 0; k < DEPTH; k++) begin
         exp = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
         a = (k < wa_q.size()) ? wa_q[k] : 'x;
         d = (k < wd_q.size()) ? wd_q[k] : 'x;
         n_cmp++;
         if ({a, d} !== {PCW'(k), exp}) begin
            n_bad++;
            $display("FAIL depth_write%0d: got addr %0d data %h want addr %0d data %h", k, a, d, k, exp);
         end
      end
      n_cmp++;
      if ({instr_count, done_cnt, err_cnt} !== {9'd256, 32'd1, 32'd0}) begin
         n_bad++;
         $display("FAIL depth_result: count=%0d done=%0d err=%0d want 256/1/0", instr_count, done_cnt, err_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [PCW-1:0] a;
      logic [W-1:0]   d;
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hDE, 1'b1);
      @(negedge clk);
      uart_rx = 1'b0;
      wait_cycles(4 * CPB);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_busy_before: got %b want 1", busy);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({wr_en, busy, load_done, load_err, fsm_hold, instr_count} !== {5'b00001, 9'd0}) begin
         n_bad++;
         $display("FAIL midrst_outputs: flags=%b count=%0d want 00001/0", {wr_en, busy, load_done, load_err, fsm_hold}, instr_count);
      end
      uart_rx = 1'b1;
      wait_cycles(5);
      rst = 1'b0;
      wait_cycles(10);
      n_cmp++;
      if ({err_cnt, 32'(wa_q.size())} !== {32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL midrst_no_err: err=%0d writes=%0d want 0/0", err_cnt, wa_q.size());
      end
      tx_q = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
      send_tx();
      wait_cycles(20);
      a = (wa_q.size() > 0) ? wa_q[0] : 'x;
      d = (wd_q.size() > 0) ? wd_q[0] : 'x;
      n_cmp++;
      if ({32'(wa_q.size()), a, d, done_cnt} !== {32'd1, 8'd0, 32'hCAFEBABE, 32'd1}) begin
         n_bad++;
         $display("FAIL midrst_reload: n=%0d addr=%0d data=%h done=%0d want 1/0/cafebabe/1", wa_q.size(), a, d, done_cnt);
      end
      n_cmp++;
      if ({instr_count, fsm_hold} !== {9'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_final: count=%0d hold=%b want 1/0", instr_count, fsm_hold);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_leading_noise();
      test_frame_err();
      test_timeout();
      test_full_depth();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
